// File: rtl/step_responder_pkg.sv
// Shared CPU constants: step op codes, responder state encodings and bus widths
// used by the timing generator and the step responder.
package step_responder_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DCNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_DELAY = 2'b11
    } step_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DELAY  = 2'b10,
        ST_DONE   = 2'b11
    } resp_state_t;

    // True for the ops that go out on the memory bus.
    function automatic logic is_mem_op(input step_op_t op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/step_timeout_cnt.sv
// Loadable up/down counter: counts up for the ACCESS timeout, down for DELAY.
module step_timeout_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [CNT_W-1:0] count
);

    // Load has priority over counting; counting direction chosen by up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (up) begin
                count <= count + CNT_W'(1);
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_responder.sv
// Step responder: turns timing-generator step pulses into memory accesses,
// delays or no-ops, and answers each accepted step with one done pulse.
module step_responder
    import step_responder_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [1:0]        step_op,
    input  logic [ADDR_W-1:0] step_addr,
    input  logic [DATA_W-1:0] step_wdata,
    input  logic [DCNT_W-1:0] delay_cnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err,
    output logic              step_lost
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TO_W > DCNT_W) ? TO_W : DCNT_W;
    // Counter starts at 0 on entry to ACCESS, so the last allowed cycle sees TIMEOUT-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    resp_state_t      state;
    resp_state_t      state_next;
    step_op_t         op_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_up;
    logic             timeout_hit;
    logic             read_hit;
    logic             step_accept;

    step_timeout_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (cnt)
    );

    assign step_accept = (state == ST_IDLE) && step;
    // An ack on the final allowed cycle wins over the timeout.
    assign timeout_hit = (state == ST_ACCESS) && !mem_ack && (cnt == TO_LAST);
    assign read_hit    = (state == ST_ACCESS) && mem_ack && (op_q == OP_READ);

    assign mem_req = (state == ST_ACCESS);
    assign mem_we  = (state == ST_ACCESS) && (op_q == OP_WRITE);
    assign done    = (state == ST_DONE);
    assign busy    = (state != ST_IDLE);

    // State register; reset forces IDLE at once so mem_req drops asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and counter control.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        cnt_up       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (step) begin
                    cnt_load = 1'b1;
                    if (is_mem_op(step_op_t'(step_op))) begin
                        state_next = ST_ACCESS;
                    end else if ((step_op_t'(step_op) == OP_DELAY) && (delay_cnt != '0)) begin
                        state_next   = ST_DELAY;
                        cnt_load_val = CNT_W'(delay_cnt);
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                cnt_up = 1'b1;
                if (mem_ack || (cnt == TO_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DELAY: begin
                cnt_en = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the request fields of an accepted step; they stay put for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NOP;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (step_accept) begin
            op_q      <= step_op_t'(step_op);
            mem_addr  <= step_addr;
            mem_wdata <= step_wdata;
        end
    end

    // Read data capture, sticky timeout flag and dropped-step pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            err       <= 1'b0;
            step_lost <= 1'b0;
        end else begin
            step_lost <= step && (state != ST_IDLE);
            if (read_hit) begin
                rdata <= mem_rdata;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_step_responder.sv
// Bench for step_responder: timeline model built from the latency rules,
// per-cycle compare process, directed scenarios with literal expectations,
// then a randomized run.
module tb_step_responder;
    import step_responder_pkg::*;

    localparam int T = 15;
    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step = 1'b0;
    logic [1:0] step_op = 2'b00;
    logic [7:0] step_addr = 8'h00;
    logic [7:0] step_wdata = 8'h00;
    logic [3:0] delay_cnt = 4'h0;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic       done;
    logic [7:0] rdata;
    logic       busy;
    logic       err;
    logic       step_lost;

    step_responder #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .step_op    (step_op),
        .step_addr  (step_addr),
        .step_wdata (step_wdata),
        .delay_cnt  (delay_cnt),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .rdata      (rdata),
        .busy       (busy),
        .err        (err),
        .step_lost  (step_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle, filled in when a step is accepted.
    bit       e_req[N];
    bit       e_we[N];
    bit       e_done[N];
    bit       e_busy[N];
    bit       e_lost[N];
    bit       e_err[N];
    bit [7:0] e_addr[N];
    bit [7:0] e_wdata[N];
    bit [7:0] e_rdata[N];
    bit       ack_at[N];
    bit [7:0] rv_at[N];

    int total = 0;
    int bad = 0;
    bit rst_hold = 1'b1;
    int last_c = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    // Timeline of one accepted step, from the latency rules.
    task automatic model_step(input int c, input logic [1:0] op, input logic [7:0] a,
                              input logic [7:0] wd, input int dc, input int k, input logic [7:0] rv);
        int d;
        bit mem;
        if (e_busy[c]) begin
            e_lost[c+1] = 1'b1;
            return;
        end
        mem = (op == OP_READ) || (op == OP_WRITE);
        if (op == OP_NOP || (op == OP_DELAY && dc == 0)) d = c + 1;
        else if (op == OP_DELAY) d = c + dc + 1;
        else if (k < T) d = c + k + 2;
        else d = c + T + 1;
        for (int i = c + 1; i <= d; i++) begin
            e_busy[i] = 1'b1;
            if (mem && i < d) begin
                e_req[i]   = 1'b1;
                e_we[i]    = (op == OP_WRITE);
                e_addr[i]  = a;
                e_wdata[i] = wd;
            end
        end
        e_done[d] = 1'b1;
        if (mem && k < T) begin
            ack_at[c+1+k] = 1'b1;
            rv_at[c+1+k]  = rv;
            if (op == OP_READ) for (int i = d; i < N; i++) e_rdata[i] = rv;
        end
        if (mem && k >= T) for (int i = d; i < N; i++) e_err[i] = 1'b1;
    endtask

    task automatic model_reset(input int c);
        for (int i = c; i < N; i++) begin
            e_req[i] = 0; e_we[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_lost[i] = 0;
            e_err[i] = 0; e_addr[i] = 0; e_wdata[i] = 0; e_rdata[i] = 0;
            ack_at[i] = 0; rv_at[i] = 0;
        end
    endtask

    // One clock of stimulus, driven just after the rising edge.
    task automatic tick(input bit st, input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                        input int dc, input int k, input logic [7:0] rv);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        last_c = c;
        if (c >= N - 40) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", c, c, N - 40);
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "cycle budget exhausted");
        end
        rst_n = !rst_hold;
        if (rst_hold) model_reset(c);
        step       = st && !rst_hold;
        step_op    = op;
        step_addr  = a;
        step_wdata = wd;
        delay_cnt  = 4'(dc);
        if (step) model_step(c, op, a, wd, dc, k, rv);
        mem_ack   = ack_at[c] | (!e_req[c] && ($urandom_range(0, 3) == 0));
        mem_rdata = ack_at[c] ? rv_at[c] : 8'($urandom);
    endtask

    task automatic idle();
        tick(1'b0, 2'b00, 8'h00, 8'h00, 0, T + 3, 8'h00);
    endtask

    // Issue a step, then idle until done; report latency and mem_req cycles.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                          input int dc, input int k, input logic [7:0] rv,
                          output int s, output int lat, output int reqc);
        tick(1'b1, op, a, wd, dc, k, rv);
        s = last_c;
        lat = -1;
        reqc = 0;
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (mem_req === 1'b1) reqc++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            chk("mem_req", mem_req, e_req[cyc]);
            chk("mem_we", mem_we, e_we[cyc]);
            chk("done", done, e_done[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("step_lost", step_lost, e_lost[cyc]);
            chk("err", err, e_err[cyc]);
            chk("rdata", rdata, e_rdata[cyc]);
            if (e_req[cyc]) begin
                chk("mem_addr", mem_addr, e_addr[cyc]);
                chk("mem_wdata", mem_wdata, e_wdata[cyc]);
            end
        end
    end

    initial begin
        int s, lat, reqc, dn, ln, cnt;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) idle();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_step_lost", step_lost, 0);
        rst_hold = 1'b0;
        repeat (2) idle();

        // NOP
        run_op(OP_NOP, 8'h00, 8'h00, 0, T + 3, 8'h00, s, lat, reqc);
        chk("nop_latency", lat, 1);
        chk("nop_req_cycles", reqc, 0);
        idle();

        // READ 0x3C, ack 3 cycles after mem_req rises
        run_op(OP_READ, 8'h3C, 8'h00, 0, 3, 8'hA5, s, lat, reqc);
        chk("read_latency", lat, 5);
        chk("read_req_cycles", reqc, 4);
        chk("read_rdata", rdata, 8'hA5);
        chk("read_err", err, 0);
        chk("model_read_done", e_done[s+5], 1);
        chk("model_read_rdata", e_rdata[s+5], 8'hA5);
        idle();

        // DELAY 4 and DELAY 0
        run_op(OP_DELAY, 8'h00, 8'h00, 4, T + 3, 8'h00, s, lat, reqc);
        chk("delay4_latency", lat, 5);
        chk("model_delay4_done", e_done[s+5], 1);
        run_op(OP_DELAY, 8'h00, 8'h00, 0, T + 3, 8'h00, s, lat, reqc);
        chk("delay0_latency", lat, 1);
        idle();

        // Ack on the last allowed cycle counts as success
        run_op(OP_READ, 8'h81, 8'h00, 0, T - 1, 8'h3E, s, lat, reqc);
        chk("lastack_latency", lat, 16);
        chk("lastack_req_cycles", reqc, 15);
        chk("lastack_err", err, 0);
        chk("lastack_rdata", rdata, 8'h3E);
        idle();

        // WRITE with no ack times out
        run_op(OP_WRITE, 8'h10, 8'h5A, 0, T + 2, 8'h00, s, lat, reqc);
        chk("timeout_latency", lat, 16);
        chk("timeout_req_cycles", reqc, 15);
        chk("timeout_err", err, 1);
        chk("timeout_rdata", rdata, 8'h3E);
        cnt = 0;
        for (int i = s + 1; i <= s + 20; i++) cnt += e_req[i];
        chk("model_timeout_req_cycles", cnt, 15);
        idle();

        // Second step two cycles into a READ is dropped
        tick(1'b1, OP_READ, 8'h21, 8'h00, 0, 5, 8'h99);
        idle();
        tick(1'b1, OP_NOP, 8'h00, 8'h00, 0, T + 3, 8'h00);
        dn = 0;
        ln = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            if (i == 0) chk("lost_pulse", step_lost, 1);
            if (done === 1'b1) dn++;
            if (step_lost === 1'b1) ln++;
        end
        chk("lost_done_count", dn, 1);
        chk("lost_pulse_count", ln, 1);
        chk("lost_rdata", rdata, 8'h99);
        chk("lost_err_sticky", err, 1);

        // Reset in the middle of an access
        tick(1'b1, OP_READ, 8'h44, 8'h00, 0, 10, 8'h11);
        idle();
        idle();
        chk("pre_reset_req", mem_req, 1);
        rst_hold = 1'b1;
        idle();
        #1;
        chk("reset_req_drop", mem_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_rdata", rdata, 0);
        idle();
        rst_hold = 1'b0;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            if (done === 1'b1) dn++;
        end
        chk("reset_no_done", dn, 0);
        run_op(OP_READ, 8'h55, 8'h00, 0, 1, 8'h77, s, lat, reqc);
        chk("post_reset_latency", lat, 3);
        chk("post_reset_rdata", rdata, 8'h77);
        chk("post_reset_err", err, 0);

        // Randomized traffic, including steps while busy and stray acks
        for (int i = 0; i < 2200; i++) begin
            tick($urandom_range(0, 3) == 0, 2'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 15), $urandom_range(0, T + 3), 8'($urandom));
        end
        repeat (20) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_responder.md
STEP_RESPONDER -- requirements
Module: step_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles mem_req waits for mem_ack.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port step  input  1  one-cycle request pulse from timing generator (T1_Mif/T2_Mif/T1..T4).
REQ-005 SHALL have port step_op  input  2  00 NOP, 01 READ, 10 WRITE, 11 DELAY; sampled with step.
REQ-006 SHALL have port step_addr  input  8  memory address; sampled with step.
REQ-007 SHALL have port step_wdata  input  8  write data; sampled with step.
REQ-008 SHALL have port delay_cnt  input  4  DELAY length in cycles; sampled with step.
REQ-009 SHALL have port mem_req  output  1  memory request, held until ack or timeout.
REQ-010 SHALL have port mem_we  output  1  1 = write, valid while mem_req.
REQ-011 SHALL have port mem_addr  output  8  registered address, valid while mem_req.
REQ-012 SHALL have port mem_wdata  output  8  registered write data, valid while mem_req.
REQ-013 SHALL have port mem_rdata  input  8  read data, valid in mem_ack cycle.
REQ-014 SHALL have port mem_ack  input  1  one-cycle completion from memory.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse back to timing generator.
REQ-016 SHALL have port rdata  output  8  last successful read data, held until next READ completes.
REQ-017 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-018 SHALL have port err  output  1  sticky timeout flag.
REQ-019 SHALL have port step_lost  output  1  one-cycle pulse when step arrives while busy.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DELAY, DONE.
REQ-021 IDLE + step: latch op/addr/wdata/delay_cnt; READ/WRITE -> ACCESS; DELAY with delay_cnt>0 -> DELAY; NOP or DELAY with delay_cnt=0 -> DONE.
REQ-022 ACCESS: mem_req=1, mem_we=(op==WRITE), addr/wdata stable; timeout counter increments each cycle.
REQ-023 ACCESS + mem_ack: READ latches mem_rdata into rdata; -> DONE; mem_req deasserts next cycle.
REQ-024 ACCESS + no ack for TIMEOUT cycles: set err, rdata unchanged, -> DONE.
REQ-025 mem_ack in the same cycle the timeout limit is reached SHALL count as success (ack wins).
REQ-026 mem_ack outside ACCESS SHALL be ignored.
REQ-027 DELAY: load counter with delay_cnt, decrement per cycle, -> DONE when counter reaches 1 (delay_cnt cycles in DELAY).
REQ-028 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-029 Latency step->done: NOP 1 cycle; READ/WRITE with ack k cycles after mem_req rises = k+2; DELAY n = n+1.
REQ-030 step while busy (including DONE cycle) SHALL be dropped, step_lost=1 next cycle, state unaffected.
REQ-031 err SHALL stay set until reset; subsequent operations proceed normally.
REQ-032 Undefined state encodings SHALL recover to IDLE.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, mem_req/mem_we/done/busy/err/step_lost=0, mem_addr/mem_wdata/rdata=0, counters=0.
REQ-034 Reset mid-ACCESS SHALL drop mem_req asynchronously; no done generated for the aborted step.

Structure
REQ-035 Op codes (NOP/READ/WRITE/DELAY) and state encodings SHALL live in the shared CPU package with the timing generator's constants.
REQ-036 One sub-module natural: step_timeout_cnt (loadable down/up counter shared by ACCESS timeout and DELAY).

Verification
REQ-037 NOP step -> done exactly 1 cycle later, mem_req never asserted.
REQ-038 READ addr 0x3C, mem_ack 3 cycles after mem_req with rdata 0xA5 -> rdata=0xA5, done 5 cycles after step, err=0.
REQ-039 WRITE addr 0x10 data 0x5A, no ack -> mem_req high 15 cycles, err=1, done pulse, rdata unchanged.
REQ-040 DELAY delay_cnt=4 -> done 5 cycles after step; delay_cnt=0 -> done 1 cycle after step.
REQ-041 Second step 2 cycles into READ -> step_lost pulse, only one done.
REQ-042 rst_n low during ACCESS -> mem_req low same cycle, no done, next READ succeeds.
